// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
// Shares one serial line between N_REQ requesters with round-robin arbitration
// and sends the granted word as: start(0), DATA_W data bits LSB first, parity,
// stop(1), then GAP idle-high cycles. All outputs are registered.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous reset, active low
//   i_req         per-requester request level, held until granted
//   i_req_data    requester i word at [i*DATA_W +: DATA_W]
//   o_grant       one-hot 1-cycle pulse in the start-bit cycle
//   o_tx_out      serial line, idle high
//   o_busy        high from the start bit through the last gap cycle
//   o_owner       requester owning the current/last frame
//   o_frame_done  1-cycle pulse in the stop-bit cycle
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, arbitrate on every edge
// START  | start bit (0), grant pulse visible
// DATA   | DATA_W data bits from the shift register, LSB first
// PARITY | parity of the latched word
// STOP   | stop bit (1), frame_done pulse
// GAP    | line high for GAP cycles; last cycle also arbitrates
module serial_tx_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_W     = 7,
   parameter bit PARITY_ODD = 1'b0,
   parameter int GAP        = 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [N_REQ-1:0]          i_req,
   input  logic [N_REQ*DATA_W-1:0]   i_req_data,
   output logic [N_REQ-1:0]          o_grant,
   output logic                      o_tx_out,
   output logic                      o_busy,
   output logic [$clog2(N_REQ)-1:0]  o_owner,
   output logic                      o_frame_done
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int GAP_W = $clog2(GAP + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_GAP
   } state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_ptr;
   logic [DATA_W-1:0]   r_shreg;
   logic                r_parity;
   logic [CNT_W-1:0]    r_bit_cnt;
   logic [GAP_W-1:0]    r_gap_cnt;
   logic [N_REQ-1:0]    r_grant;
   logic                r_tx;
   logic                r_busy;
   logic [IDX_W-1:0]    r_owner;
   logic                r_frame_done;

   logic                w_any;
   logic                w_hit;
   logic [IDX_W-1:0]    w_win;
   logic [IDX_W-1:0]    w_ptr_nxt;
   logic [N_REQ-1:0]    w_grant;
   logic [DATA_W-1:0]   w_word;
   logic                w_launch;

   // Scanning downwards lets the lowest index at/after the pointer win;
   // indices below the pointer only count when nothing at/after it is set.
   always_comb begin
      w_any = |i_req;
      w_hit = 1'b0;
      w_win = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (i_req[j]) begin
            if (j >= int'(r_ptr)) begin
               w_win = IDX_W'(j);
               w_hit = 1'b1;
            end else if (!w_hit) begin
               w_win = IDX_W'(j);
            end
         end
      end
   end

   always_comb begin
      w_grant = '0;
      w_word  = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (w_win == IDX_W'(j)) begin
            w_grant[j] = 1'b1;
            w_word     = i_req_data[j*DATA_W +: DATA_W];
         end
      end
   end

   assign w_ptr_nxt = (w_win == IDX_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;

   // Arbitration in the last gap cycle keeps back-to-back frames at
   // DATA_W+3+GAP cycles instead of paying an extra IDLE cycle.
   assign w_launch = w_any &&
                     ((r_state == S_IDLE) || ((r_state == S_GAP) && (r_gap_cnt == '0)));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_shreg      <= '0;
         r_parity     <= 1'b0;
         r_bit_cnt    <= '0;
         r_gap_cnt    <= '0;
         r_grant      <= '0;
         r_tx         <= 1'b1;
         r_busy       <= 1'b0;
         r_owner      <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_grant      <= '0;
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
            end
            S_START: begin
               r_state   <= S_DATA;
               r_tx      <= r_shreg[0];
               r_shreg   <= r_shreg >> 1;
               r_bit_cnt <= '0;
            end
            S_DATA: begin
               if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                  r_state <= S_PARITY;
                  r_tx    <= r_parity;
               end else begin
                  r_tx      <= r_shreg[0];
                  r_shreg   <= r_shreg >> 1;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            S_PARITY: begin
               r_state      <= S_STOP;
               r_tx         <= 1'b1;
               r_frame_done <= 1'b1;
            end
            S_STOP: begin
               r_state   <= S_GAP;
               r_tx      <= 1'b1;
               r_gap_cnt <= GAP_W'(GAP - 1);
            end
            S_GAP: begin
               r_tx <= 1'b1;
               if (r_gap_cnt == '0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase

         if (w_launch) begin
            r_state  <= S_START;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
            r_grant  <= w_grant;
            r_owner  <= w_win;
            r_ptr    <= w_ptr_nxt;
            r_shreg  <= w_word;
            r_parity <= (^w_word) ^ PARITY_ODD;
         end
      end
   end

   assign o_grant      = r_grant;
   assign o_tx_out     = r_tx;
   assign o_busy       = r_busy;
   assign o_owner      = r_owner;
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter
// Directed stimulus pushes the hand-computed frame (owner, word, parity) into
// a queue; a monitor decodes every granted frame off the serial line and
// compares it with the head of the queue. A second instance with odd parity
// covers the parity polarity.
module tb_serial_tx_arbiter;

   localparam int N = 4;
   localparam int W = 7;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [W-1:0]   words [N];
   logic [N*W-1:0] req_data;
   logic [N-1:0]   grant;
   logic           tx_out, busy, frame_done;
   logic [1:0]     owner;

   logic [N-1:0]   req_o;
   logic [N*W-1:0] data_o;
   logic [N-1:0]   grant_o;
   logic           tx_o, busy_o, frame_done_o;
   logic [1:0]     owner_o;

   assign req_data = {words[3], words[2], words[1], words[0]};

   always #5 clk = ~clk;

   serial_tx_arbiter #(.N_REQ(N), .DATA_W(W), .PARITY_ODD(1'b0), .GAP(1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_data(req_data),
      .o_grant(grant), .o_tx_out(tx_out), .o_busy(busy), .o_owner(owner),
      .o_frame_done(frame_done)
   );

   serial_tx_arbiter #(.N_REQ(N), .DATA_W(W), .PARITY_ODD(1'b1), .GAP(1)) dut_o (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req_o), .i_req_data(data_o),
      .o_grant(grant_o), .o_tx_out(tx_o), .o_busy(busy_o), .o_owner(owner_o),
      .o_frame_done(frame_done_o)
   );

   typedef struct {
      int           idx;
      logic [W-1:0] word;
      logic         par;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic push(input int idx, input logic [W-1:0] wd, input logic p);
      exp_t e;
      e.idx  = idx;
      e.word = wd;
      e.par  = p;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input bit use_o, output bit got);
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         tick();
         if (use_o ? (grant_o != '0) : (grant != '0)) got = 1'b1;
      end
      if (!got) chk(1'b0, "grant_timeout", 32'h0, 32'h1);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         if (!busy) done = 1'b1;
         else tick();
      end
      if (!done) chk(1'b0, "idle_timeout", 32'h1, 32'h0);
   endtask

   // Monitor: decodes one frame per grant, sampling on the falling edge.
   initial begin : monitor
      exp_t         e;
      logic [W-1:0] w;
      logic [N-1:0] exp_g;
      logic         par, stop, fd_par, fd_stop, gap_tx, gap_busy;
      bit           live;
      forever begin
         @(negedge clk);
         if (rst_n && grant != '0) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_grant", 32'(grant), 32'h0);
            end else begin
               e     = exp_q.pop_front();
               exp_g = 4'b0001 << e.idx;
               chk(grant == exp_g, "grant_onehot", 32'(grant), 32'(exp_g));
               chk(int'(owner) == e.idx, "owner", 32'(owner), 32'(e.idx));
               chk(tx_out == 1'b0, "start_bit", 32'(tx_out), 32'h0);
               chk(busy == 1'b1, "busy_start", 32'(busy), 32'h1);
               live = 1'b1;
               w = '0; par = 1'b0; stop = 1'b0; fd_par = 1'b0; fd_stop = 1'b0;
               gap_tx = 1'b0; gap_busy = 1'b0;
               for (int b = 0; b < W + 3; b++) begin
                  @(negedge clk);
                  if (!rst_n) begin
                     live = 1'b0;
                     break;
                  end
                  if (b < W) begin
                     w = {tx_out, w[W-1:1]};
                  end else if (b == W) begin
                     par    = tx_out;
                     fd_par = frame_done;
                  end else if (b == W + 1) begin
                     stop    = tx_out;
                     fd_stop = frame_done;
                  end else begin
                     gap_tx   = tx_out;
                     gap_busy = busy;
                  end
               end
               if (live) begin
                  chk(w == e.word, "data_word", 32'(w), 32'(e.word));
                  chk(par == e.par, "parity_bit", 32'(par), 32'(e.par));
                  chk(fd_par == 1'b0, "frame_done_early", 32'(fd_par), 32'h0);
                  chk(stop == 1'b1, "stop_bit", 32'(stop), 32'h1);
                  chk(fd_stop == 1'b1, "frame_done_stop", 32'(fd_stop), 32'h1);
                  chk(gap_tx == 1'b1, "gap_line_high", 32'(gap_tx), 32'h1);
                  chk(gap_busy == 1'b1, "gap_busy", 32'(gap_busy), 32'h1);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin : stim
      bit got;
      int last;
      rst_n  = 1'b0;
      req    = '0;
      req_o  = '0;
      data_o = '0;
      last   = 0;
      for (int i = 0; i < N; i++) words[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk(tx_out == 1'b1, "rst_tx", 32'(tx_out), 32'h1);
      chk(grant == 4'b0000, "rst_grant", 32'(grant), 32'h0);
      chk(busy == 1'b0, "rst_busy", 32'(busy), 32'h0);
      chk(owner == 2'd0, "rst_owner", 32'(owner), 32'h0);
      chk(frame_done == 1'b0, "rst_frame_done", 32'(frame_done), 32'h0);
      chk(tx_o == 1'b1, "rst_tx_odd", 32'(tx_o), 32'h1);
      rst_n = 1'b1;
      tick();
      tick();

      // Odd-parity instance: 7'h41 has two ones -> parity bit 1.
      data_o = {21'b0, 7'h41};
      req_o  = 4'b0001;
      wait_grant(1'b1, got);
      req_o = '0;
      chk(grant_o == 4'b0001, "odd_grant", 32'(grant_o), 32'h1);
      chk(tx_o == 1'b0, "odd_start", 32'(tx_o), 32'h0);
      repeat (W + 1) tick();
      chk(tx_o == 1'b1, "odd_parity", 32'(tx_o), 32'h1);
      chk(frame_done_o == 1'b0, "odd_fd_parity", 32'(frame_done_o), 32'h0);
      tick();
      chk(frame_done_o == 1'b1, "odd_fd_stop", 32'(frame_done_o), 32'h1);
      chk(tx_o == 1'b1, "odd_stop", 32'(tx_o), 32'h1);

      // Single requester; data changes after the grant must not leak in.
      words[0] = 7'b0000111;
      push(0, 7'b0000111, 1'b1);
      req = 4'b0001;
      wait_grant(1'b0, got);
      req      = '0;
      words[0] = 7'h78;
      wait_idle();

      // Reset during the 3rd data bit (bit2 of 7'h0B is 0).
      words[0] = 7'h0B;
      push(0, 7'h0B, 1'b1);
      req = 4'b0001;
      wait_grant(1'b0, got);
      req = '0;
      repeat (3) tick();
      chk(tx_out == 1'b0, "pre_rst_bit2", 32'(tx_out), 32'h0);
      #2 rst_n = 1'b0;
      #1;
      chk(tx_out == 1'b1, "midrst_tx", 32'(tx_out), 32'h1);
      chk(busy == 1'b0, "midrst_busy", 32'(busy), 32'h0);
      chk(grant == 4'b0000, "midrst_grant", 32'(grant), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      words[0] = 7'h55;
      words[1] = 7'h01;
      push(0, 7'h55, 1'b0);
      push(1, 7'h01, 1'b1);
      req = 4'b0011;
      wait_grant(1'b0, got);
      chk(grant == 4'b0001, "post_rst_first", 32'(grant), 32'h1);
      req[0] = 1'b0;
      wait_grant(1'b0, got);
      req[1] = 1'b0;
      wait_idle();

      // All requests held from a fresh pointer: 0,1,2,3,0 at 11-cycle spacing.
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      words[0] = 7'h15;
      words[1] = 7'h2A;
      words[2] = 7'h7F;
      words[3] = 7'h00;
      push(0, 7'h15, 1'b1);
      push(1, 7'h2A, 1'b1);
      push(2, 7'h7F, 1'b1);
      push(3, 7'h00, 1'b0);
      push(0, 7'h03, 1'b0);
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_grant(1'b0, got);
         if (g > 0) chk(cyc - last == 11, "rr_spacing", 32'(cyc - last), 32'd11);
         last = cyc;
         if (g == 0) words[0] = 7'h03;
         if (g == 4) req = '0;
      end
      wait_idle();

      // req[2] rises mid-frame, req[1] pulses and drops: next grant is 2.
      words[0] = 7'h7E;
      words[1] = 7'h5A;
      words[2] = 7'h33;
      push(0, 7'h7E, 1'b0);
      push(2, 7'h33, 1'b0);
      req = 4'b0001;
      wait_grant(1'b0, got);
      req = '0;
      repeat (3) tick();
      req[2] = 1'b1;
      tick();
      req[1] = 1'b1;
      tick();
      tick();
      req[1] = 1'b0;
      wait_grant(1'b0, got);
      chk(grant == 4'b0100, "skip_dropped_req", 32'(grant), 32'h4);
      req[2] = 1'b0;
      wait_idle();

      // Receiver-style words, back to back (pointer is at 3 now).
      words[3] = 7'b1110000;
      words[1] = 7'b1000001;
      push(3, 7'b1110000, 1'b1);
      push(1, 7'b1000001, 1'b0);
      req = 4'b1010;
      wait_grant(1'b0, got);
      chk(grant == 4'b1000, "loop_first", 32'(grant), 32'h8);
      req[3] = 1'b0;
      wait_grant(1'b0, got);
      chk(grant == 4'b0010, "loop_second", 32'(grant), 32'h2);
      req[1] = 1'b0;
      wait_idle();

      repeat (3) tick();
      chk(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
